// File: rtl/aes_core_iter.sv
// aes_core_iter -- iterative AES encryption core (AES-128/192/256).
//   One round per ROUND_CYC clocks, own round counter and start/ready
//   handshake. Round keys are fetched from an external key schedule by
//   key_idx and must be valid combinationally in the same cycle.
// Parameters:
//   KEY_BITS   128/192/256 -> NR = 10/12/14 rounds
//   ROUND_CYC  1..4 cycles per round (one extra datapath register per step)
// Ports:
//   clk        rising-edge clock
//   kill_n     asynchronous active-low reset; aborts a block in flight
//   start      load in_data when ready=1 (ignored otherwise)
//   in_data    128-bit plaintext
//   ready      1 when idle
//   key_idx    round-key index requested (0..NR)
//   key_round  round key for key_idx
//   out_data   ciphertext, held until the next completion
//   out_valid  one-cycle pulse when out_data is new
// Optional (macro AES_CORE_STATUS_EN):
//   round_cnt  current round in RUN, 0 when idle
//   err_start  sticky flag: start seen while busy; cleared only by kill_n
module aes_core_iter #(
  parameter int KEY_BITS  = 128,
  parameter int ROUND_CYC = 4
) (
  input  logic         clk,
  input  logic         kill_n,
  input  logic         start,
  input  logic [127:0] in_data,
  output logic         ready,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_round,
  output logic [127:0] out_data,
  output logic         out_valid
`ifdef AES_CORE_STATUS_EN
  ,
  output logic [3:0]   round_cnt,
  output logic [0:0]   err_start
`endif
);

  localparam int         NR      = (KEY_BITS == 128) ? 10 : (KEY_BITS == 192) ? 12 : 14;
  localparam logic [3:0] NR4     = 4'(NR);
  localparam logic [1:0] LASTCYC = 2'(ROUND_CYC - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_core_iter: KEY_BITS must be 128, 192 or 256");
  end
  if (ROUND_CYC < 1 || ROUND_CYC > 4) begin : g_bad_cyc
    $error("aes_core_iter: ROUND_CYC must be 1..4");
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as x^254 (maps 0 to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Byte i = row + 4*col, byte 0 in bits [127:120].
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  typedef enum logic {IDLE, RUN} state_e;
  state_e st_q, st_d;

  logic [127:0] state_q, state_d, out_q, out_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [1:0]   cyc_q, cyc_d;
  logic         valid_q, valid_d;
  logic [127:0] sb_in, sr, mc_in, mc, fin;
  logic         last, round_end;

  assign last      = (rnd_q == NR4);
  assign round_end = (st_q == RUN) && (cyc_q == LASTCYC);

  // Pipeline stages are free-running; state_q is constant for the whole
  // round, so the stage values have settled by the cyc==ROUND_CYC-1 edge.
  if (ROUND_CYC >= 4) begin : g_sb_reg
    logic [127:0] sbin_q;
    always_ff @(posedge clk or negedge kill_n) begin
      if (!kill_n) sbin_q <= '0;
      else         sbin_q <= state_q;
    end
    assign sb_in = sbin_q;
  end else begin : g_sb_comb
    assign sb_in = state_q;
  end

  assign sr = sub_shift(sb_in);

  if (ROUND_CYC >= 2) begin : g_sr_reg
    logic [127:0] sr_q;
    always_ff @(posedge clk or negedge kill_n) begin
      if (!kill_n) sr_q <= '0;
      else         sr_q <= sr;
    end
    assign mc_in = sr_q;
  end else begin : g_sr_comb
    assign mc_in = sr;
  end

  assign mc = last ? mc_in : mix(mc_in);

  if (ROUND_CYC >= 3) begin : g_mc_reg
    logic [127:0] mc_q;
    always_ff @(posedge clk or negedge kill_n) begin
      if (!kill_n) mc_q <= '0;
      else         mc_q <= mc;
    end
    assign fin = mc_q;
  end else begin : g_mc_comb
    assign fin = mc;
  end

  // FSM state register
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) st_q <= IDLE;
    else         st_q <= st_d;
  end

  // FSM next state
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (start) st_d = RUN;
      RUN:     if (round_end && last) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready   = (st_q == IDLE);
    key_idx = (st_q == IDLE) ? '0 : rnd_q;
  end

  // Datapath next state
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    cyc_d   = cyc_q;
    out_d   = out_q;
    valid_d = 1'b0;
    case (st_q)
      IDLE: begin
        if (start) begin
          state_d = in_data ^ key_round;
          rnd_d   = 4'd1;
          cyc_d   = '0;
        end
      end
      RUN: begin
        if (round_end) begin
          cyc_d   = '0;
          state_d = fin ^ key_round;
          if (last) begin
            out_d   = fin ^ key_round;
            valid_d = 1'b1;
            rnd_d   = '0;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end else begin
          cyc_d = cyc_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state_q <= '0;
      rnd_q   <= '0;
      cyc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      cyc_q   <= cyc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = out_q;
  assign out_valid = valid_q;

`ifdef AES_CORE_STATUS_EN
  logic err_q;
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n)                err_q <= 1'b0;
    else if (start && !ready)   err_q <= 1'b1;
  end
  assign round_cnt = key_idx;
  assign err_start = err_q;
`endif

endmodule

// File: tb/tb_aes_core_iter.sv
// tb_aes_core_iter -- directed FIPS-197 vectors against four aes_core_iter
// configurations (128/4, 192/4, 256/4, 256/1). The bench expands keys
// itself and serves key_round from key_idx like the external schedule.
module tb_aes_core_iter;

  localparam int KB [4] = '{128, 192, 256, 256};
  localparam int RC [4] = '{4, 4, 4, 1};

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KB128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PTB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic kill_n;
  logic [3:0]        start, ready, out_valid;
  logic [3:0][127:0] in_data, out_data, key_round;
  logic [3:0][3:0]   key_idx;
`ifdef AES_CORE_STATUS_EN
  logic [3:0][3:0]   round_cnt;
  logic [3:0]        err_start;
`endif
  logic [127:0] rk [4][16];
  logic [7:0]   sbt [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign key_round[g] = rk[g][key_idx[g]];
    aes_core_iter #(.KEY_BITS(KB[g]), .ROUND_CYC(RC[g])) u_dut (
      .clk       (clk),
      .kill_n    (kill_n),
      .start     (start[g]),
      .in_data   (in_data[g]),
      .ready     (ready[g]),
      .key_idx   (key_idx[g]),
      .key_round (key_round[g]),
      .out_data  (out_data[g]),
      .out_valid (out_valid[g])
`ifdef AES_CORE_STATUS_EN
      ,
      .round_cnt (round_cnt[g]),
      .err_start (err_start[g][0:0])
`endif
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Polynomial product then reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (tmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int k = 0; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
      sbt[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  task automatic expand(input int u, input int kb, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = kb / 32;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[u][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Called at #1 after an edge; the next edge accepts the block.
  task automatic launch(input int u, input logic [127:0] pt);
    chk("ready_before_start", 128'(ready[u]), 128'd1);
    chk("kidx_at_accept", 128'(key_idx[u]), 128'd0);
    in_data[u] = pt;
    start[u]   = 1'b1;
    @(posedge clk);
    #1;
    start[u] = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, with a bound.
  task automatic finish_blk(input int u, input logic [127:0] ct, input int lat,
                            input string tag, input bit trace, input bit hold_en,
                            input logic [127:0] hold, input int poke_at);
    int seen_at;
    seen_at = -1;
    for (int e = 1; e <= lat + 8 && seen_at < 0; e++) begin
      @(posedge clk);
      #1;
      start[u] = 1'b0;
      if (out_valid[u]) begin
        seen_at = e;
      end else begin
        if (trace) begin
          chk({tag, "_kidx"}, 128'(key_idx[u]), 128'(e / RC[u] + 1));
`ifdef AES_CORE_STATUS_EN
          chk({tag, "_rcnt"}, 128'(round_cnt[u]), 128'(e / RC[u] + 1));
`endif
        end
        if (hold_en) chk({tag, "_hold"}, out_data[u], hold);
        if (e == poke_at) begin
          in_data[u] = ~ct;
          start[u]   = 1'b1;
        end
      end
    end
    chk({tag, "_latency"}, 128'(seen_at), 128'(lat));
    chk({tag, "_ct"}, out_data[u], ct);
    chk({tag, "_ready_at_valid"}, 128'(ready[u]), 128'd1);
    if (trace) chk({tag, "_kidx_done"}, 128'(key_idx[u]), 128'd0);
  endtask

  initial begin
    int pulses;
    kill_n  = 1'b0;
    start   = '0;
    in_data = '0;
    build_sbox();
    expand(0, 128, K128);
    expand(1, 192, K192);
    expand(2, 256, K256);
    expand(3, 256, K256);
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u += 3) begin
      chk("rst_ready", 128'(ready[u]), 128'd1);
      chk("rst_valid", 128'(out_valid[u]), 128'd0);
      chk("rst_data", out_data[u], 128'd0);
      chk("rst_kidx", 128'(key_idx[u]), 128'd0);
    end
    kill_n = 1'b1;
    @(posedge clk);
    #1;

    // C.1 with key-index trace, then the pulse must drop while data holds
    launch(0, PT);
    finish_blk(0, CT128, 40, "c1", 1'b1, 1'b0, '0, 0);
    @(posedge clk);
    #1;
    chk("c1_pulse_width", 128'(out_valid[0]), 128'd0);
    chk("c1_data_held", out_data[0], CT128);

    // C.2 / C.3 and the one-cycle-per-round build
    launch(1, PT);
    finish_blk(1, CT192, 48, "c2", 1'b1, 1'b0, '0, 0);
    launch(2, PT);
    finish_blk(2, CT256, 56, "c3", 1'b1, 1'b0, '0, 0);
    launch(3, PT);
    finish_blk(3, CT256, 14, "c3_rc1", 1'b1, 1'b0, '0, 0);

    // Back-to-back: second block (different key) accepted in the out_valid cycle
    launch(0, PT);
    finish_blk(0, CT128, 40, "b2b_a", 1'b0, 1'b0, '0, 0);
    expand(0, 128, KB128);
    launch(0, PTB);
    finish_blk(0, CTB, 40, "b2b_b", 1'b0, 1'b1, CT128, 0);
    expand(0, 128, K128);
    @(posedge clk);
    #1;

    // Start pulsed during round 3 must be ignored
    launch(0, PT);
    finish_blk(0, CT128, 40, "busy", 1'b0, 1'b0, '0, 9);
`ifdef AES_CORE_STATUS_EN
    chk("err_start_set", 128'(err_start[0]), 128'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_start_sticky", 128'(err_start[0]), 128'd1);
`endif
    @(posedge clk);
    #1;

    // Kill during round 5
    launch(0, PT);
    repeat (17) @(posedge clk);
    #2;
    kill_n = 1'b0;
    #1;
    chk("kill_ready", 128'(ready[0]), 128'd1);
    chk("kill_valid", 128'(out_valid[0]), 128'd0);
    chk("kill_data", out_data[0], 128'd0);
    chk("kill_kidx", 128'(key_idx[0]), 128'd0);
`ifdef AES_CORE_STATUS_EN
    chk("kill_err_clear", 128'(err_start[0]), 128'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    kill_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid[0]) pulses++;
    end
    chk("kill_no_valid", 128'(pulses), 128'd0);
    launch(0, PT);
    finish_blk(0, CT128, 40, "post_kill", 1'b0, 1'b0, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
